// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if
//   Request and response bus between the angle-producing clients and the
//   shared CORDIC arbiter.
//   Request side : req_valid[N_REQ], req_angle[18*N_REQ] (slice i = requester i),
//                  req_ready[N_REQ] (one-hot accept strobe).
//   Response side: rsp_valid, rsp_ready, rsp_id, rsp_cos, rsp_sin, rsp_angle,
//                  rsp_err (00 ok, 01 out of range, 10 timeout).
//   master = client side, slave = arbiter side.
interface cordic_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [18*N_REQ-1:0] req_angle;
    logic [N_REQ-1:0]    req_ready;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [17:0]         rsp_cos;
    logic [17:0]         rsp_sin;
    logic [17:0]         rsp_angle;
    logic [1:0]          rsp_err;

    modport master (
        output req_valid, req_angle, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_angle, rsp_err
    );

    modport slave (
        input  req_valid, req_angle, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_angle, rsp_err
    );
endinterface

// File: rtl/cordic_arbiter.sv
// cordic_arbiter
//   Shares one iterative CORDIC core among N_REQ requesters. Requests are
//   granted round-robin, range-checked, launched with a one-cycle init pulse
//   and answered on a single tagged response bus with backpressure.
//   All angle/cos/sin values are signed 2.16 fixed point, 18 bits.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : request/response bus, see cordic_arbiter_if
//   busy              : high in every state except IDLE
//   cordic_init       : one-cycle init pulse to the core
//   cordic_angle      : angle to the core, stable from LAUNCH to end of WAIT
//   cordic_done       : core done (level, may be stale right after init)
//   cordic_cos/sin    : core results
//   cordic_angle_out  : core residual angle
module cordic_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int ANGLE_MAX = 102944,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    cordic_arbiter_if.slave bus,
    output logic        busy,
    output logic        cordic_init,
    output logic [17:0] cordic_angle,
    input  logic        cordic_done,
    input  logic [17:0] cordic_cos,
    input  logic [17:0] cordic_sin,
    input  logic [17:0] cordic_angle_out
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic signed [17:0] ANG_HI = 18'(ANGLE_MAX);
    localparam logic signed [17:0] ANG_LO = -ANG_HI;

    state_t            state, state_nx;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [17:0]       cos_q, sin_q, ang_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic              found_hi, found_lo, gnt_found;
    logic [ID_W-1:0]   idx_hi, idx_lo, gnt_idx;
    logic signed [17:0] ang_hi, ang_lo, gnt_angle;
    logic              gnt_oor;
    logic              done_ok, timed_out;

    // Round-robin search: the first valid index above the pointer wins;
    // if none, the first valid index at or below it (wrap-around).
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        ang_hi   = '0;
        ang_lo   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (ID_W'(i) > ptr && !found_hi) begin
                    found_hi = 1'b1;
                    idx_hi   = ID_W'(i);
                    ang_hi   = bus.req_angle[18*i +: 18];
                end
                if (ID_W'(i) <= ptr && !found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = ID_W'(i);
                    ang_lo   = bus.req_angle[18*i +: 18];
                end
            end
        end
        gnt_found = found_hi || found_lo;
        gnt_idx   = found_hi ? idx_hi : idx_lo;
        gnt_angle = found_hi ? ang_hi : ang_lo;
        // The most negative code falls below ANG_LO, so it is rejected too.
        gnt_oor   = (gnt_angle > ANG_HI) || (gnt_angle < ANG_LO);
    end

    // The core's done level may still be high from the previous operation
    // during the first WAIT cycle, so it is only trusted from cycle two on.
    assign done_ok   = (state == WAIT) && (wait_cnt != '0) && cordic_done;
    assign timed_out = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1)) && !done_ok;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    for (int i = 0; i < N_REQ; i++)
                        bus.req_ready[i] = (gnt_idx == ID_W'(i));
                    state_nx = gnt_oor ? RESP : LAUNCH;
                end
            end
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (done_ok || timed_out) state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign cordic_init   = (state == LAUNCH);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_cos   = cos_q;
    assign bus.rsp_sin   = sin_q;
    assign bus.rsp_angle = ang_q;
    assign bus.rsp_err   = err_q;

    // Datapath: capture on grant, fill response on done/timeout, hold in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            cos_q        <= '0;
            sin_q        <= '0;
            ang_q        <= '0;
            err_q        <= ERR_OK;
            cordic_angle <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        ptr          <= gnt_idx;
                        id_q         <= gnt_idx;
                        cordic_angle <= gnt_angle;
                        if (gnt_oor) begin
                            cos_q <= '0;
                            sin_q <= '0;
                            ang_q <= gnt_angle;
                            err_q <= ERR_RANGE;
                        end
                    end
                end
                LAUNCH: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (done_ok) begin
                        cos_q <= cordic_cos;
                        sin_q <= cordic_sin;
                        ang_q <= cordic_angle_out;
                        err_q <= ERR_OK;
                    end else if (timed_out) begin
                        cos_q <= '0;
                        sin_q <= '0;
                        ang_q <= '0;
                        err_q <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter
//   Drives cordic_arbiter through a vector table plus hand-written corner
//   sequences. A behavioural core model answers init requests with rounded
//   real cos/sin after a fixed latency and keeps done stale for one cycle
//   after each init. Expected responses are queued at request time and
//   compared in order when a response handshake is observed.
module tb_cordic_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy, cordic_init, cordic_done;
    logic [17:0] cordic_angle, cordic_cos, cordic_sin, cordic_angle_out;

    cordic_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    cordic_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .ANGLE_MAX(102944), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .busy             (busy),
        .cordic_init      (cordic_init),
        .cordic_angle     (cordic_angle),
        .cordic_done      (cordic_done),
        .cordic_cos       (cordic_cos),
        .cordic_sin       (cordic_sin),
        .cordic_angle_out (cordic_angle_out)
    );

    always #5 clk = ~clk;

    // ---------------- core model ----------------
    logic              core_hang = 1'b0;
    logic              m_active;
    int                m_cnt;
    logic signed [17:0] m_ang;
    int                init_cnt = 0;

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    endfunction

    always @(posedge clk) if (cordic_init) init_cnt <= init_cnt + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cordic_done      <= 1'b0;
            cordic_cos       <= '0;
            cordic_sin       <= '0;
            cordic_angle_out <= '0;
            m_active         <= 1'b0;
            m_cnt            <= 0;
            m_ang            <= '0;
        end else if (cordic_init) begin
            m_ang    <= cordic_angle;
            m_cnt    <= LAT;
            m_active <= 1'b1;
        end else if (m_active) begin
            if (core_hang) begin
                cordic_done <= 1'b0;
            end else if (m_cnt == 0) begin
                cordic_done      <= 1'b1;
                m_active         <= 1'b0;
                cordic_cos       <= 18'(rnd($cos($itor(m_ang) / 65536.0) * 65536.0));
                cordic_sin       <= 18'(rnd($sin($itor(m_ang) / 65536.0) * 65536.0));
                cordic_angle_out <= 18'sd1;
            end else begin
                cordic_done <= 1'b0;
                m_cnt       <= m_cnt - 1;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        int id;
        int cos;
        int sin;
        int ang;
        int err;
        int tol;
    } exp_t;

    typedef struct {
        int id;
        int angle;
        int cos;
        int sin;
        int ang;
        int err;
        bit last;
    } vec_t;

    exp_t sb[$];
    vec_t vec[7];
    int   total = 0;
    int   bad   = 0;

    logic             s_valid, s_busy, s_init;
    logic [N_REQ-1:0] s_rr;
    logic [17:0]      s_cos, s_sin, s_ang;
    logic [1:0]       s_err;
    logic [ID_W-1:0]  s_id;
    logic [N_REQ-1:0] acc;

    task automatic check(input string name, input int act, input int exp, input int tol);
        int d;
        total++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (tol %0d) t=%0t", name, act, exp, tol, $time);
        end
    endtask

    task automatic compare_rsp();
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_rsp", 1, 0, 0);
        end else begin
            e = sb.pop_front();
            check("rsp_id",    int'(bus.rsp_id), e.id, 0);
            check("rsp_err",   int'(bus.rsp_err), e.err, 0);
            check("rsp_cos",   int'($signed(bus.rsp_cos)), e.cos, e.tol);
            check("rsp_sin",   int'($signed(bus.rsp_sin)), e.sin, e.tol);
            check("rsp_angle", int'($signed(bus.rsp_angle)), e.ang, e.tol);
        end
    endtask

    // One clock: sample at the falling edge, apply request clears after the rising edge.
    task automatic step();
        @(negedge clk);
        s_valid = bus.rsp_valid;
        s_busy  = busy;
        s_init  = cordic_init;
        s_rr    = bus.req_ready;
        s_cos   = bus.rsp_cos;
        s_sin   = bus.rsp_sin;
        s_ang   = bus.rsp_angle;
        s_err   = bus.rsp_err;
        s_id    = bus.rsp_id;
        acc     = bus.req_valid & bus.req_ready;
        if (bus.rsp_valid && bus.rsp_ready) compare_rsp();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~acc;
    endtask

    task automatic raise(input int id, input int angle);
        bus.req_angle[18*id +: 18] = 18'(angle);
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic send(input int id, input int angle, input int c, input int s,
                        input int a, input int err, input int tol);
        exp_t e;
        e = '{id: id, cos: c, sin: s, ang: a, err: err, tol: tol};
        sb.push_back(e);
        raise(id, angle);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            step();
            n++;
        end
        check("drain_budget", sb.size(), 0, 0);
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        s_init = 1'b0;
        while (!s_init && n < 10) begin
            step();
            n++;
        end
        check("init_seen", int'(s_init), 1, 0);
    endtask

    initial begin
        int ic0, n_core, cnt;
        logic hold_ok;
        logic [17:0] h_cos, h_sin, h_ang;
        logic [1:0]  h_err;
        logic [ID_W-1:0] h_id;

        vec[0] = '{0,       0, 65536,      2,       0, 0, 1'b0};
        vec[1] = '{1,  102944,     2,  65536,       0, 0, 1'b0};
        vec[2] = '{2,   25736, 60546,  25081,       0, 0, 1'b0};
        vec[3] = '{3,  -51472, 46343, -46342,       0, 0, 1'b1};
        vec[4] = '{0,   51472, 46341,  46342,       0, 0, 1'b1};
        vec[5] = '{2,  110000,     0,      0,  110000, 1, 1'b1};
        vec[6] = '{2, -131072,     0,      0, -131072, 1, 1'b1};

        bus.req_valid = '0;
        bus.req_angle = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",      int'(busy), 0, 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0, 0);
        check("rst_req_ready", int'(bus.req_ready), 0, 0);
        check("rst_init",      int'(cordic_init), 0, 0);
        check("rst_rsp_data",  int'(bus.rsp_cos | bus.rsp_sin | bus.rsp_angle), 0, 0);
        check("rst_cordic_angle", int'(cordic_angle), 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table: simultaneous group first so the pointer starts from reset.
        ic0 = init_cnt;
        n_core = 0;
        for (int i = 0; i < 7; i++) begin
            send(vec[i].id, vec[i].angle, vec[i].cos, vec[i].sin, vec[i].ang,
                 vec[i].err, (vec[i].err == 0) ? 2 : 0);
            if (vec[i].err == 0) n_core++;
            if (vec[i].last) begin
                if (vec[i].err == 1) begin
                    step();
                    check("oor_grant", int'(s_rr), 1 << vec[i].id, 0);
                    step();
                    check("oor_latency", int'(s_valid), 1, 0);
                end
                drain();
                check("init_pulses", init_cnt - ic0, n_core, 0);
                ic0 = init_cnt;
                n_core = 0;
            end
        end

        // Backpressure: response must hold while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        send(1, 25736, 60546, 25081, 0, 0, 2);
        cnt = 0;
        s_valid = 1'b0;
        while (!s_valid && cnt < 50) begin
            step();
            cnt++;
        end
        check("bp_rsp_valid", int'(s_valid), 1, 0);
        h_cos = s_cos; h_sin = s_sin; h_ang = s_ang; h_err = s_err; h_id = s_id;
        send(3, 0, 65536, 0, 0, 0, 2);
        for (int i = 0; i < 20; i++) begin
            step();
            hold_ok = s_valid && s_busy && (s_rr == '0) && (s_cos == h_cos) &&
                      (s_sin == h_sin) && (s_ang == h_ang) && (s_err == h_err) && (s_id == h_id);
            check("bp_hold", int'(hold_ok), 1, 0);
        end
        bus.rsp_ready = 1'b1;
        step();
        step();
        check("bp_one_cycle", int'(s_valid), 0, 0);
        check("bp_next_grant", int'(s_rr), 4'b1000, 0);
        drain();

        // Hung core: timeout exactly TIMEOUT cycles into WAIT, then recovery.
        core_hang = 1'b1;
        send(0, 0, 0, 0, 0, 2, 0);
        wait_init();
        cnt = 0;
        s_valid = 1'b0;
        while (!s_valid && cnt < TIMEOUT + 10) begin
            step();
            cnt++;
        end
        check("timeout_latency", cnt, TIMEOUT + 1, 0);
        core_hang = 1'b0;
        send(1, 51472, 46341, 46342, 0, 0, 2);
        drain();

        // Reset during WAIT abandons the transaction and restores the pointer.
        raise(2, 25736);
        wait_init();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  int'(busy), 0, 0);
        check("mid_rst_valid", int'(bus.rsp_valid), 0, 0);
        check("mid_rst_init",  int'(cordic_init), 0, 0);
        check("mid_rst_angle", int'(cordic_angle), 0, 0);
        bus.req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 0, 65536, 0, 0, 0, 2);
        send(3, 25736, 60546, 25081, 0, 0, 2);
        step();
        check("post_rst_grant", int'(s_rr), 4'b0001, 0);
        drain();
        repeat (3) step();
        check("sb_empty", sb.size(), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one iterative CORDIC core among N_REQ requesters.
- Arbitrates round-robin and range-checks each angle before launch.
- Sequences the core's init/done protocol and returns tagged cos/sin/angle results on one response bus with backpressure.
- Sits between the angle-producing clients and the single CORDIC instance. All angles, cos and sin values are signed 2.16 fixed point, 18 bits.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= N_REQ.
- ANGLE_MAX, 102944, largest legal |angle| (pi/2 in 2.16).
- TIMEOUT, 64, WAIT cycles allowed before the core is declared hung.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_angle  in  18*N_REQ  per-requester signed 2.16 angle; slice i = bits [18*i+17 : 18*i].
- req_ready  out  N_REQ  one-hot accept strobe.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_cos  out  18  signed 2.16 cosine.
- rsp_sin  out  18  signed 2.16 sine.
- rsp_angle  out  18  core residual angle, or the echoed input on error.
- rsp_err  out  2  00 ok, 01 out of range, 10 timeout.
- busy  out  1  high in every state except IDLE.
- cordic_init  out  1  init to the core.
- cordic_angle  out  18  angle_in to the core; held stable from LAUNCH to the end of WAIT.
- cordic_done  in  1  done from the core; level signal.
- cordic_cos  in  18  core result.
- cordic_sin  in  18  core result.
- cordic_angle_out  in  18  core result.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - State = IDLE.
  - req_ready=0, rsp_valid=0, cordic_init=0, busy=0.
  - rsp_* data=0, cordic_angle=0.
  - RR pointer = N_REQ-1, so requester 0 has top priority first.
  - Reset mid-operation abandons the transaction with no response.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid index after the pointer, searching upward with wrap.
  - Drive req_ready[g]=1 combinationally for that cycle only. Transfer occurs on that edge.
  - Capture angle and id; update pointer = g.
  - If |angle| > ANGLE_MAX (the most negative code counts as out of range): go to RESP with err=01, cos=sin=0, rsp_angle=input angle. The core is not used.
  - Otherwise go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - cordic_init=1 and cordic_angle=captured angle; the init pulse spans one rising edge.
  - Then go to WAIT and clear the watchdog counter.
- WAIT:
  - cordic_done is ignored in the first WAIT cycle, because the core's done may be stale from the previous op.
  - From the second cycle, done=1 latches cordic_cos, cordic_sin and cordic_angle_out into the rsp registers with err=00, then go to RESP.
  - If the counter reaches TIMEOUT first: err=10, data=0, go to RESP.
- RESP:
  - rsp_valid=1, with all rsp_* held stable until rsp_valid && rsp_ready.
  - On that edge go to IDLE. No new grant in the same cycle; req_ready is 0 in RESP.
- Latency:
  - Accept at edge k, init high in cycle k+1.
  - Done first seen at edge d gives rsp_valid from cycle d+1.
  - Out-of-range request: rsp_valid from cycle k+1.
- Fairness: a requester holding valid waits at most N_REQ-1 other transactions.
- Requesters must hold req_angle stable while req_valid=1 and not yet accepted.
- The arbiter never issues init while a transaction is in flight.

Test Plan:
- Single request, id 0, angle 51472 (pi/4) -> one init pulse; response id=0, err=00, cos 46341, sin 46342 (±2 LSB), angle ≈0.
- All four requesters valid at once with angles 0, 102944, 25736, -51472 -> grant order 0,1,2,3. Results respectively:
  - cos 65536, sin ≈2
  - cos ≈2, sin 65536
  - cos 60546, sin 25081
  - cos 46343, sin -46342
- Requester 2 sends 110000 -> rsp_valid next cycle, err=01, cos=sin=0, rsp_angle=110000, cordic_init never asserted. Same check with -131072.
- Hold rsp_ready=0 for 20 cycles after a response -> rsp_* stable, busy=1, no req_ready. Then rsp_ready=1 -> one-cycle handshake, back to IDLE.
- Core model ties done low -> err=10 exactly TIMEOUT cycles into WAIT. Next request then completes normally.
- Assert rst_n=0 during WAIT -> outputs go to reset values immediately. Next request from requester 3 alongside 0 -> requester 0 is granted first.
